mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 52 +++++
 rtl/mem_responder.sv | 177 +++++++++++++++++
 tb/tb_mem_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared definitions for the memory responder.
//   - RV32I load/store funct3 encodings
//   - responder FSM state enum
//   - funct3_valid(): whether a funct3 is a legal load/store encoding
package mem_resp_pkg;

    localparam logic [2:0] Funct3Lb  = 3'd0;
    localparam logic [2:0] Funct3Lh  = 3'd1;
    localparam logic [2:0] Funct3Lw  = 3'd2;
    localparam logic [2:0] Funct3Lbu = 3'd4;
    localparam logic [2:0] Funct3Lhu = 3'd5;
    localparam logic [2:0] Funct3Sb  = 3'd0;
    localparam logic [2:0] Funct3Sh  = 3'd1;
    localparam logic [2:0] Funct3Sw  = 3'd2;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } mem_state_e;

    function automatic logic funct3_valid(input logic we, input logic [2:0] funct3);
        if (we) begin
            return funct3 <= Funct3Sw;
        end
        return !(funct3 == 3'd3 || funct3 == 3'd6 || funct3 == 3'd7);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane logic for the memory responder.
//   i_funct3    : effective funct3 (already normalised by the caller)
//   i_byte_off  : byte offset within the word
//   i_rd_word   : current contents of the addressed word
//   i_wdata     : right-aligned store data
//   o_load_data : load result, sign/zero extended per funct3
//   o_wr_word   : i_rd_word with the addressed store lanes replaced
module mem_lane_align
    import mem_resp_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_byte_off,
    input  logic [31:0] i_rd_word,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_wr_word
);

    logic [31:0] w_rd_shift;
    logic [31:0] w_wr_shift;
    logic [3:0]  w_lane_en;

    assign w_rd_shift = i_rd_word >> {i_byte_off, 3'b000};
    assign w_wr_shift = i_wdata << {i_byte_off, 3'b000};

    always_comb begin
        o_load_data = i_rd_word;
        case (i_funct3)
            Funct3Lb:  o_load_data = {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            Funct3Lh:  o_load_data = {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            Funct3Lbu: o_load_data = {24'b0, w_rd_shift[7:0]};
            Funct3Lhu: o_load_data = {16'b0, w_rd_shift[15:0]};
            default:   o_load_data = i_rd_word;
        endcase
    end

    always_comb begin
        w_lane_en = 4'b1111;
        case (i_funct3[1:0])
            2'd0:    w_lane_en = 4'b0001 << i_byte_off;
            2'd1:    w_lane_en = 4'b0011 << i_byte_off;
            default: w_lane_en = 4'b1111;
        endcase
        o_wr_word = i_rd_word;
        for (int i = 0; i < 4; i++) begin
            if (w_lane_en[i]) begin
                o_wr_word[8*i +: 8] = w_wr_shift[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// mem_responder: single-outstanding RV32I load/store memory responder with
// configurable wait states.
//   clk, rst_n                          : clock, async active-low reset
//   req_valid/req_ready                 : request handshake (ready only in idle)
//   req_we, req_funct3, req_addr, req_wdata : request fields, latched on accept
//   rsp_valid/rsp_ready                 : response handshake
//   rsp_rdata, rsp_err                  : load result / fault flag, held until handshake
// Build option MEM_RESPONDER_ERR_EN: report misaligned, illegal-funct3 and
// out-of-range accesses as errors instead of aligning/wrapping them.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WaitLast = 4'(WAIT_CYCLES == 0 ? 0 : WAIT_CYCLES - 1);

    mem_state_e  r_state, w_state_d;
    logic [3:0]  r_cnt, w_cnt_d;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_enter_resp, w_wr_en, w_err;
    logic          w_cur_we;
    logic [2:0]    w_cur_funct3, w_funct3;
    logic [31:0]   w_cur_addr, w_cur_wdata;
    logic [1:0]    w_off;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word, w_load_data, w_wr_word;
    logic          w_unused_addr;

    assign req_ready = (r_state == StIdle) && rst_n;
    assign w_accept  = req_valid && req_ready;
    assign rsp_valid = (r_state == StResp);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    // In the accept cycle the fields come straight from the ports (needed when
    // WAIT_CYCLES is 0); afterwards only the latched copy is used.
    always_comb begin
        w_cur_we     = r_we;
        w_cur_funct3 = r_funct3;
        w_cur_addr   = r_addr;
        w_cur_wdata  = r_wdata;
        if (r_state == StIdle) begin
            w_cur_we     = req_we;
            w_cur_funct3 = req_funct3;
            w_cur_addr   = req_addr;
            w_cur_wdata  = req_wdata;
        end
    end

`ifdef MEM_RESPONDER_ERR_EN
    always_comb begin
        w_funct3 = w_cur_funct3;
        w_off    = w_cur_addr[1:0];
        w_err    = !funct3_valid(w_cur_we, w_cur_funct3)
                || (w_cur_funct3[1:0] == 2'd1 && w_cur_addr[0])
                || (w_cur_funct3[1:0] == 2'd2 && w_cur_addr[1:0] != 2'b00)
                || ({2'b00, w_cur_addr[31:2]} >= 32'(DEPTH_WORDS));
    end
`else
    // Illegal encodings fall back to a full word; offsets align down to size.
    always_comb begin
        w_funct3 = funct3_valid(w_cur_we, w_cur_funct3) ? w_cur_funct3 : Funct3Lw;
        w_err    = 1'b0;
        case (w_funct3[1:0])
            2'd0:    w_off = w_cur_addr[1:0];
            2'd1:    w_off = {w_cur_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end
`endif

    // Upper address bits only matter for the range check.
    assign w_unused_addr = ^w_cur_addr[31:AW+2];
    assign w_idx         = w_cur_addr[AW+1:2];
    assign w_rd_word     = r_mem[w_idx];

    mem_lane_align u_lane_align (
        .i_funct3    (w_funct3),
        .i_byte_off  (w_off),
        .i_rd_word   (w_rd_word),
        .i_wdata     (w_cur_wdata),
        .o_load_data (w_load_data),
        .o_wr_word   (w_wr_word)
    );

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_d    = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (r_cnt == WaitLast) begin
                    w_state_d    = StResp;
                    w_enter_resp = 1'b1;
                    w_cnt_d      = 4'd0;
                end else begin
                    w_cnt_d = r_cnt + 4'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // Stores commit only on entry to RESP, so a reset during WAIT loses them.
    assign w_wr_en = w_enter_resp && w_cur_we && !w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_cur_we || w_err) ? 32'd0 : w_load_data;
            end
        end
    end

    // Memory array is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_idx] <= w_wr_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized self-checking bench for mem_responder.
// Main instance uses WAIT_CYCLES = 3 and a small memory; a second instance
// with WAIT_CYCLES = 0 and rsp_ready tied high exercises back-to-back traffic.
// Expected results come from a byte-addressed reference memory.
module tb_mem_responder;

    localparam int unsigned DEPTH = 64;
    localparam int unsigned W     = 3;

    localparam logic [2:0] LB = 3'd0, LH = 3'd1, LW = 3'd2, LBU = 3'd4, LHU = 3'd5;
    localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid0, req_ready0, req_we0;
    logic [2:0]  req_funct3_0;
    logic [31:0] req_addr0, req_wdata0;
    logic        rsp_valid0, rsp_err0;
    logic [31:0] rsp_rdata0;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] mem_b [4*DEPTH];

    always #5 clk = ~clk;

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_we     (req_we0),
        .req_funct3 (req_funct3_0),
        .req_addr   (req_addr0),
        .req_wdata  (req_wdata0),
        .rsp_valid  (rsp_valid0),
        .rsp_ready  (1'b1),
        .rsp_rdata  (rsp_rdata0),
        .rsp_err    (rsp_err0)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: byte memory, little-endian lanes.
    task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rdata,
                                output logic err);
        int unsigned size;
        int unsigned base;
        bit          sgn;
        bit          ok;
        logic [31:0] v;
        sgn   = 1'b0;
        ok    = 1'b1;
        size  = 4;
        err   = 1'b0;
        rdata = 32'd0;
        if (we) begin
            ok   = (f3 <= 3'd2);
            size = ok ? (1 << f3) : 4;
        end else begin
            case (f3)
                3'd0: begin size = 1; sgn = 1'b1; end
                3'd1: begin size = 2; sgn = 1'b1; end
                3'd2: size = 4;
                3'd4: size = 1;
                3'd5: size = 2;
                default: begin ok = 1'b0; size = 4; end
            endcase
        end
`ifdef MEM_RESPONDER_ERR_EN
        if (!ok || (addr % size) != 0 || (addr / 4) >= DEPTH) begin
            err = 1'b1;
            return;
        end
`endif
        base = (addr - addr % size) % (4 * DEPTH);
        if (we) begin
            for (int i = 0; i < int'(size); i++) mem_b[base + i] = wdata[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mem_b[base + i];
        if (sgn && v[8*size-1]) begin
            for (int i = 8 * int'(size); i < 32; i++) v[i] = 1'b1;
        end
        rdata = v;
    endtask

    // One transaction on the main instance; optionally holds rsp_ready low for
    // 'hold' cycles and pokes a competing request meanwhile.
    task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold, input bit poke,
                          output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          n;
        model_access(we, f3, addr, wdata, exp_rdata, exp_err);
        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: the responder must use the latched copy.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        n = 1;
        while (!rsp_valid && n < 64) begin
            @(negedge clk);
            n++;
        end
        check_eq("latency", 32'(n), 32'(1 + W));
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        check_eq("rdata", got_rdata, exp_rdata);
        check_eq("err", 32'(got_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                req_valid  = 1'b1;
                req_we     = 1'b1;
                req_funct3 = SW;
                req_addr   = 32'h0;
                req_wdata  = 32'hBAD0BAD0;
            end
            @(negedge clk);
            check_eq("hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("hold_rdata", rsp_rdata, got_rdata);
            check_eq("hold_err", 32'(rsp_err), 32'(got_err));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b0;
        check_eq("hs_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("post_hs_valid", 32'(rsp_valid), 32'd0);
        check_eq("post_hs_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [2:0]  ld_ops [5];
        logic [31:0] d0 [8];
        logic [31:0] exp_q [$];
        int          issued, got, cyc;

        ld_ops = '{LB, LH, LW, LBU, LHU};
        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        rsp_ready = 1'b0;
        req_valid0 = 1'b0; req_we0 = 1'b0; req_funct3_0 = 3'd0; req_addr0 = 32'd0;
        req_wdata0 = 32'd0;

        repeat (2) @(negedge clk);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'd0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        rst_n = 1'b1;

        for (int w = 0; w < int'(DEPTH); w++) begin
            do_txn(1'b1, SW, 32'(4 * w), $urandom, 0, 1'b0, rd, er);
        end

        do_txn(1'b1, SW, 32'h10, 32'hDEADBEEF, 0, 1'b0, rd, er);
        do_txn(1'b0, LW, 32'h10, 32'h0, 0, 1'b0, rd, er);
        check_eq("lw10", rd, 32'hDEADBEEF);
        check_eq("lw10_err", 32'(er), 32'd0);
        do_txn(1'b0, LB, 32'h13, 32'h0, 0, 1'b0, rd, er);
        check_eq("lb13", rd, 32'hFFFFFFDE);
        do_txn(1'b0, LBU, 32'h13, 32'h0, 1, 1'b0, rd, er);
        check_eq("lbu13", rd, 32'h000000DE);
        do_txn(1'b0, LHU, 32'h12, 32'h0, 0, 1'b0, rd, er);
        check_eq("lhu12", rd, 32'h0000DEAD);
        do_txn(1'b1, SB, 32'h11, 32'h55, 0, 1'b0, rd, er);
        do_txn(1'b0, LW, 32'h10, 32'h0, 0, 1'b0, rd, er);
        check_eq("lw10_sb", rd, 32'hDEAD55EF);

        // Stalled response with a competing request pending.
        do_txn(1'b0, LW, 32'h10, 32'h0, 5, 1'b1, rd, er);
        check_eq("stall_rdata", rd, 32'hDEAD55EF);
        do_txn(1'b0, LW, 32'h0, 32'h0, 0, 1'b0, rd, er);

        do_txn(1'b0, LW, 32'h12, 32'h0, 0, 1'b0, rd, er);
`ifdef MEM_RESPONDER_ERR_EN
        check_eq("lw12_err", 32'(er), 32'd1);
        check_eq("lw12_rdata", rd, 32'd0);
`endif
        do_txn(1'b1, SW, 32'(4 * DEPTH), 32'hCAFEF00D, 0, 1'b0, rd, er);
`ifdef MEM_RESPONDER_ERR_EN
        check_eq("sw_oor_err", 32'(er), 32'd1);
`endif
        do_txn(1'b0, LW, 32'h0, 32'h0, 0, 1'b0, rd, er);

        // Reset while a store sits in WAIT: memory must be unchanged.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h20;
        req_wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("wait_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_ready", 32'(req_ready), 32'd0);
        check_eq("mid_rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_txn(1'b0, LW, 32'h20, 32'h0, 0, 1'b0, rd, er);

        for (int t = 0; t < 150; t++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                f3 = we ? 3'($urandom_range(0, 2)) : ld_ops[$urandom_range(0, 4)];
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            addr = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 4*DEPTH-1));
            do_txn(we, f3, addr, $urandom, $urandom_range(0, 2), 1'b0, rd, er);
        end

        // Back-to-back traffic on the zero-wait instance, rsp_ready tied high.
        for (int i = 0; i < 8; i++) d0[i] = $urandom;
        issued = 0;
        got    = 0;
        cyc    = 0;
        @(negedge clk);
        while (got < 16 && cyc < 200) begin
            if (rsp_valid0) begin
                check_eq("b2b_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) check_eq("b2b_rdata", rsp_rdata0, exp_q.pop_front());
                check_eq("b2b_err", 32'(rsp_err0), 32'd0);
                got++;
            end
            if (issued < 16) begin
                req_valid0   = 1'b1;
                req_we0      = (issued < 8);
                req_funct3_0 = (issued < 8) ? SW : LW;
                req_addr0    = 32'(4 * (issued % 8));
                req_wdata0   = d0[issued % 8];
                if (req_ready0) begin
                    exp_q.push_back((issued < 8) ? 32'd0 : d0[issued % 8]);
                    issued++;
                end
            end else begin
                req_valid0 = 1'b0;
            end
            cyc++;
            if (got < 16) @(negedge clk);
        end
        req_valid0 = 1'b0;
        check_eq("b2b_count", 32'(got), 32'd16);
        check_eq("b2b_cycles", 32'(cyc), 32'd32);
        @(negedge clk);
        check_eq("b2b_no_extra", 32'(rsp_valid0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
